// File: rtl/sram_access_controller.sv
// Arbitrates NUM_CH buffered write channels and one read channel onto an asynchronous SRAM,
// owning the auto-incrementing address counter and the OE/WE strobe timing.
module sram_access_controller #(
    parameter int ADDR_W    = 19,
    parameter int DATA_W    = 8,
    parameter int NUM_CH    = 2,
    parameter int WE_CYCLES = 1,
    parameter int RD_CYCLES = 2
) (
    input  logic                     CLOCK,
    input  logic                     RESET,
    input  logic [NUM_CH-1:0]        REQ_WR,
    input  logic [NUM_CH*DATA_W-1:0] WR_DATA,
    output logic [NUM_CH-1:0]        ACK_WR,
    output logic [NUM_CH-1:0]        OVERRUN,
    input  logic                     REQ_RD,
    output logic [DATA_W-1:0]        RD_DATA,
    output logic                     RD_VALID,
    input  logic                     ADDR_LOAD,
    input  logic [ADDR_W-1:0]        ADDR_IN,
    input  logic                     FLAG_CLR,
    output logic                     BUSY,
    output logic                     EMPTY,
    output logic                     FULL,
    output logic                     DROPPED,
    output logic [ADDR_W-1:0]        SRAM_A,
    output logic [DATA_W-1:0]        SRAM_DQ_OUT,
    output logic                     SRAM_DQ_OE,
    input  logic [DATA_W-1:0]        SRAM_DQ_IN,
    output logic                     SRAM_WE_n,
    output logic                     SRAM_OE_n
);

    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int MAX_C = (WE_CYCLES > RD_CYCLES) ? WE_CYCLES : RD_CYCLES;
    localparam int CNT_W = $clog2(MAX_C + 1);
    localparam logic [CNT_W-1:0] WE_LAST = CNT_W'(WE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_OEIA, S_WRITE, S_WEND, S_INC, S_READ, S_RINC
    } state_t;

    state_t              state, next_state;
    logic [CNT_W-1:0]    cnt;
    logic [NUM_CH-1:0]   pend;
    logic                pend_rd;
    logic [DATA_W-1:0]   hold [NUM_CH];
    logic [CH_W-1:0]     gnt_ch;
    logic                gnt_drop;
    logic                wr_any;
    logic [CH_W-1:0]     wr_sel;
    logic                grant_wr, grant_rd;

    // Lowest-index pending write channel wins
    always_comb begin
        wr_any = 1'b0;
        wr_sel = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (pend[i]) begin
                wr_any = 1'b1;
                wr_sel = CH_W'(i);
            end
        end
    end

    assign grant_wr = (state == S_IDLE) && wr_any;
    assign grant_rd = (state == S_IDLE) && !wr_any && pend_rd;
    assign BUSY     = (state != S_IDLE) || (|pend) || pend_rd;
    assign EMPTY    = (SRAM_A == '0);

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (wr_any) next_state = FULL ? S_INC : S_OEIA;
                     else if (pend_rd) next_state = S_READ;
            S_OEIA:  next_state = S_WRITE;
            S_WRITE: if (cnt == WE_LAST) next_state = S_WEND;
            S_WEND:  next_state = S_INC;
            S_INC:   next_state = S_IDLE;
            S_READ:  if (cnt == RD_LAST) next_state = S_RINC;
            S_RINC:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Strobes: the bus is only driven while OE_n is high, so the SRAM never fights the controller
    always_comb begin
        SRAM_WE_n  = 1'b1;
        SRAM_OE_n  = 1'b0;
        SRAM_DQ_OE = 1'b0;
        ACK_WR     = '0;
        RD_VALID   = 1'b0;
        case (state)
            S_OEIA, S_WEND: begin
                SRAM_OE_n  = 1'b1;
                SRAM_DQ_OE = 1'b1;
            end
            S_WRITE: begin
                SRAM_OE_n  = 1'b1;
                SRAM_DQ_OE = 1'b1;
                SRAM_WE_n  = 1'b0;
            end
            S_INC: begin
                SRAM_OE_n = 1'b1;
                if (!gnt_drop) ACK_WR[gnt_ch] = 1'b1;
            end
            S_RINC:  RD_VALID = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state       <= S_IDLE;
            cnt         <= '0;
            pend        <= '0;
            pend_rd     <= 1'b0;
            gnt_ch      <= '0;
            gnt_drop    <= 1'b0;
            SRAM_DQ_OUT <= '0;
            SRAM_A      <= '0;
            FULL        <= 1'b0;
            OVERRUN     <= '0;
            DROPPED     <= 1'b0;
            RD_DATA     <= '0;
            for (int i = 0; i < NUM_CH; i++) hold[i] <= '0;
        end else begin
            state <= next_state;
            if ((state == S_WRITE || state == S_READ) && next_state == state)
                cnt <= cnt + CNT_W'(1);
            else
                cnt <= '0;

            if (FLAG_CLR) begin
                OVERRUN <= '0;
                DROPPED <= 1'b0;
            end

            // A new request overwrites the held word; the later capture is the one written
            for (int i = 0; i < NUM_CH; i++) begin
                if (REQ_WR[i]) begin
                    hold[i] <= WR_DATA[i*DATA_W +: DATA_W];
                    pend[i] <= 1'b1;
                    if (pend[i] && !(grant_wr && wr_sel == CH_W'(i))) OVERRUN[i] <= 1'b1;
                end else if (grant_wr && wr_sel == CH_W'(i)) begin
                    pend[i] <= 1'b0;
                end
            end

            if (REQ_RD)        pend_rd <= 1'b1;
            else if (grant_rd) pend_rd <= 1'b0;

            // Latch the granted word so later requests cannot disturb the bus mid-write
            if (grant_wr) begin
                gnt_ch   <= wr_sel;
                gnt_drop <= FULL;
                if (FULL) DROPPED <= 1'b1;
                else      SRAM_DQ_OUT <= hold[wr_sel];
            end

            if (state == S_READ && next_state == S_RINC) RD_DATA <= SRAM_DQ_IN;

            if (ADDR_LOAD) begin
                SRAM_A <= ADDR_IN;
                FULL   <= 1'b0;
            end else if (state == S_INC || state == S_RINC) begin
                if (&SRAM_A) FULL <= 1'b1;
                else         SRAM_A <= SRAM_A + ADDR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_sram_access_controller.sv
// Randomized scoreboard bench for sram_access_controller: a queue-based reference model predicts
// every committed write and read, and a monitor pops and compares on ACK_WR / RD_VALID.
module tb_sram_access_controller;

    localparam int ADDR_W    = 19;
    localparam int DATA_W    = 8;
    localparam int NUM_CH    = 2;
    localparam int WE_CYCLES = 1;
    localparam int RD_CYCLES = 2;
    localparam logic [ADDR_W-1:0] MAX_A = '1;

    logic                     CLOCK;
    logic                     RESET;
    logic [NUM_CH-1:0]        REQ_WR;
    logic [NUM_CH*DATA_W-1:0] WR_DATA;
    logic [NUM_CH-1:0]        ACK_WR;
    logic [NUM_CH-1:0]        OVERRUN;
    logic                     REQ_RD;
    logic [DATA_W-1:0]        RD_DATA;
    logic                     RD_VALID;
    logic                     ADDR_LOAD;
    logic [ADDR_W-1:0]        ADDR_IN;
    logic                     FLAG_CLR;
    logic                     BUSY, EMPTY, FULL, DROPPED;
    logic [ADDR_W-1:0]        SRAM_A;
    logic [DATA_W-1:0]        SRAM_DQ_OUT;
    logic                     SRAM_DQ_OE;
    logic [DATA_W-1:0]        SRAM_DQ_IN;
    logic                     SRAM_WE_n, SRAM_OE_n;

    sram_access_controller #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_CH(NUM_CH),
        .WE_CYCLES(WE_CYCLES), .RD_CYCLES(RD_CYCLES)
    ) dut (
        .CLOCK(CLOCK), .RESET(RESET), .REQ_WR(REQ_WR), .WR_DATA(WR_DATA), .ACK_WR(ACK_WR),
        .OVERRUN(OVERRUN), .REQ_RD(REQ_RD), .RD_DATA(RD_DATA), .RD_VALID(RD_VALID),
        .ADDR_LOAD(ADDR_LOAD), .ADDR_IN(ADDR_IN), .FLAG_CLR(FLAG_CLR), .BUSY(BUSY),
        .EMPTY(EMPTY), .FULL(FULL), .DROPPED(DROPPED), .SRAM_A(SRAM_A),
        .SRAM_DQ_OUT(SRAM_DQ_OUT), .SRAM_DQ_OE(SRAM_DQ_OE), .SRAM_DQ_IN(SRAM_DQ_IN),
        .SRAM_WE_n(SRAM_WE_n), .SRAM_OE_n(SRAM_OE_n)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    typedef struct {
        bit                rd;
        int                ch;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } exp_t;

    exp_t              exp_q[$];
    int                checks = 0;
    int                errors = 0;
    logic [DATA_W-1:0] sram_mem [logic [ADDR_W-1:0]];
    logic [DATA_W-1:0] ref_mem  [logic [ADDR_W-1:0]];

    logic [ADDR_W-1:0] m_addr;
    bit                m_full;
    logic [NUM_CH-1:0] m_ovr;
    bit                m_drop;

    int                we_run = 0;
    int                pulses_pending = 0;
    int                cyc_n = 0;
    int                prev_ack_cyc = 0;
    int                last_ack_gap = 0;
    logic [ADDR_W-1:0] last_we_addr;
    logic [DATA_W-1:0] last_we_data;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Unwritten SRAM locations read back as 0x5A
    function automatic logic [DATA_W-1:0] sram_peek(input logic [ADDR_W-1:0] a);
        return sram_mem.exists(a) ? sram_mem[a] : 8'h5A;
    endfunction

    function automatic logic [DATA_W-1:0] ref_peek(input logic [ADDR_W-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'h5A;
    endfunction

    task automatic m_step();
        if (m_addr == MAX_A) m_full = 1'b1;
        else                 m_addr = m_addr + 1'b1;
    endtask

    task automatic model_reset();
        m_addr = '0;
        m_full = 1'b0;
        m_ovr  = '0;
        m_drop = 1'b0;
        exp_q.delete();
    endtask

    // Requests issued together are served lowest channel first, then the read
    task automatic model_issue(input logic [NUM_CH-1:0] mask, input logic [NUM_CH*DATA_W-1:0] data,
                               input bit rd);
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (mask[ch]) begin
                if (m_full) begin
                    m_drop = 1'b1;
                end else begin
                    exp_q.push_back('{1'b0, ch, m_addr, data[ch*DATA_W +: DATA_W]});
                    ref_mem[m_addr] = data[ch*DATA_W +: DATA_W];
                end
                m_step();
            end
        end
        if (rd) begin
            exp_q.push_back('{1'b1, 0, m_addr, ref_peek(m_addr)});
            m_step();
        end
    endtask

    task automatic cyc();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic apply_stimulus(input logic [NUM_CH-1:0] mask, input logic [NUM_CH*DATA_W-1:0] data,
                                  input bit rd, input logic [NUM_CH-1:0] dbl,
                                  input logic [NUM_CH*DATA_W-1:0] dbl_data);
        logic [NUM_CH*DATA_W-1:0] final_data;
        final_data = data;
        for (int ch = 0; ch < NUM_CH; ch++)
            if (dbl[ch]) final_data[ch*DATA_W +: DATA_W] = dbl_data[ch*DATA_W +: DATA_W];
        model_issue(mask, final_data, rd);
        m_ovr = m_ovr | dbl;
        REQ_WR  = mask;
        WR_DATA = data;
        REQ_RD  = rd;
        cyc();
        if (dbl != '0) begin
            REQ_WR  = dbl;
            WR_DATA = dbl_data;
            REQ_RD  = 1'b0;
            cyc();
        end
        REQ_WR = '0;
        REQ_RD = 1'b0;
    endtask

    task automatic do_load(input logic [ADDR_W-1:0] v);
        ADDR_LOAD = 1'b1;
        ADDR_IN   = v;
        cyc();
        ADDR_LOAD = 1'b0;
        m_addr = v;
        m_full = 1'b0;
    endtask

    task automatic do_flag_clr();
        FLAG_CLR = 1'b1;
        cyc();
        FLAG_CLR = 1'b0;
        m_ovr  = '0;
        m_drop = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            cyc();
            n++;
        end while (BUSY && n < 200);
        check_output("idle_timeout", 32'(BUSY), 32'(0));
    endtask

    task automatic post_checks();
        check_output("sram_a", 32'(SRAM_A), 32'(m_addr));
        check_output("full", 32'(FULL), 32'(m_full));
        check_output("empty", 32'(EMPTY), 32'(m_addr == '0));
        check_output("overrun", 32'(OVERRUN), 32'(m_ovr));
        check_output("dropped", 32'(DROPPED), 32'(m_drop));
        check_output("pending_expect", 32'(exp_q.size()), 32'(0));
        check_output("stray_we_pulse", 32'(pulses_pending), 32'(0));
    endtask

    // SRAM model plus scoreboard monitor, sampling on the falling edge
    initial begin
        exp_t e;
        SRAM_DQ_IN = '0;
        forever begin
            @(negedge CLOCK);
            cyc_n++;
            if (!SRAM_WE_n) begin
                sram_mem[SRAM_A] = SRAM_DQ_OUT;
                last_we_addr     = SRAM_A;
                last_we_data     = SRAM_DQ_OUT;
            end
            SRAM_DQ_IN = !SRAM_OE_n ? sram_peek(SRAM_A) : 8'($urandom);
            if (RESET) begin
                we_run         = 0;
                pulses_pending = 0;
            end else begin
                check_output("dq_oe_overlap", 32'(SRAM_DQ_OE & ~SRAM_OE_n), 32'(0));
                if (!SRAM_WE_n) begin
                    we_run++;
                    check_output("we_strobes", 32'({SRAM_OE_n, SRAM_DQ_OE}), 32'(2'b11));
                end else if (we_run != 0) begin
                    check_output("we_width", 32'(we_run), 32'(WE_CYCLES));
                    pulses_pending++;
                    we_run = 0;
                end
                if (ACK_WR != '0) begin
                    last_ack_gap = cyc_n - prev_ack_cyc;
                    prev_ack_cyc = cyc_n;
                    if (exp_q.size() == 0) begin
                        check_output("unexpected_ack", 32'(ACK_WR), 32'(0));
                    end else begin
                        e = exp_q.pop_front();
                        check_output("ack_kind", 32'(e.rd), 32'(0));
                        check_output("ack_channel", 32'(ACK_WR), 32'(1 << e.ch));
                        check_output("wr_addr", 32'(last_we_addr), 32'(e.addr));
                        check_output("wr_data", 32'(last_we_data), 32'(e.data));
                        check_output("we_pulse_count", 32'(pulses_pending), 32'(1));
                    end
                    pulses_pending = 0;
                end
                if (RD_VALID) begin
                    if (exp_q.size() == 0) begin
                        check_output("unexpected_rd_valid", 32'(RD_VALID), 32'(0));
                    end else begin
                        e = exp_q.pop_front();
                        check_output("rd_kind", 32'(e.rd), 32'(1));
                        check_output("rd_data", 32'(RD_DATA), 32'(e.data));
                        check_output("rd_addr", 32'(SRAM_A), 32'(e.addr));
                    end
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [NUM_CH-1:0]        mask, dbl;
        logic [NUM_CH*DATA_W-1:0] data, dbl_data;
        logic [ADDR_W-1:0]        pick;
        bit                       rd;

        RESET = 1'b1; REQ_WR = '0; WR_DATA = '0; REQ_RD = 1'b0;
        ADDR_LOAD = 1'b0; ADDR_IN = '0; FLAG_CLR = 1'b0;
        model_reset();
        cyc();
        cyc();
        check_output("rst_sram_a", 32'(SRAM_A), 32'(0));
        check_output("rst_strobes", 32'({SRAM_WE_n, SRAM_OE_n, SRAM_DQ_OE}), 32'(3'b100));
        check_output("rst_busy", 32'(BUSY), 32'(0));
        check_output("rst_empty", 32'(EMPTY), 32'(1));
        check_output("rst_flags", 32'({FULL, OVERRUN, DROPPED}), 32'(0));
        check_output("rst_outputs", 32'({ACK_WR, RD_VALID, RD_DATA}), 32'(0));
        RESET = 1'b0;
        cyc();

        $display("[TB] single channel-0 write");
        do_load(19'h00010);
        apply_stimulus(2'b01, 16'h00A5, 1'b0, 2'b00, 16'h0);
        cyc();
        check_output("oeia_strobes", 32'({SRAM_WE_n, SRAM_OE_n, SRAM_DQ_OE}), 32'(3'b111));
        cyc();
        check_output("write_we_low", 32'(SRAM_WE_n), 32'(0));
        check_output("write_dq", 32'(SRAM_DQ_OUT), 32'(8'hA5));
        repeat (WE_CYCLES - 1) cyc();
        cyc();
        check_output("wend_strobes", 32'({SRAM_WE_n, SRAM_OE_n, SRAM_DQ_OE}), 32'(3'b111));
        check_output("wend_dq", 32'(SRAM_DQ_OUT), 32'(8'hA5));
        cyc();
        check_output("inc_ack", 32'(ACK_WR), 32'(2'b01));
        check_output("inc_addr_hold", 32'(SRAM_A), 32'(19'h00010));
        check_output("inc_dq_oe", 32'(SRAM_DQ_OE), 32'(0));
        cyc();
        check_output("post_ack", 32'(ACK_WR), 32'(0));
        check_output("post_addr", 32'(SRAM_A), 32'(19'h00011));
        check_output("post_busy", 32'(BUSY), 32'(0));
        post_checks();

        $display("[TB] simultaneous requests");
        apply_stimulus(2'b11, 16'h2211, 1'b0, 2'b00, 16'h0);
        wait_idle();
        check_output("ack_spacing", 32'(last_ack_gap), 32'(WE_CYCLES + 4));
        post_checks();

        $display("[TB] overrun on channel 1");
        apply_stimulus(2'b11, 16'h3355, 1'b0, 2'b10, 16'h4400);
        wait_idle();
        post_checks();
        do_flag_clr();
        post_checks();

        $display("[TB] full handling");
        do_load(MAX_A);
        for (int k = 0; k < 3; k++) begin
            apply_stimulus(2'b01, 16'($urandom), 1'b0, 2'b00, 16'h0);
            wait_idle();
            post_checks();
        end
        apply_stimulus(2'b00, 16'h0, 1'b1, 2'b00, 16'h0);
        wait_idle();
        post_checks();
        do_load('0);
        post_checks();

        $display("[TB] timed read");
        do_load(19'h00100);
        apply_stimulus(2'b00, 16'h0, 1'b1, 2'b00, 16'h0);
        for (int k = 0; k < RD_CYCLES; k++) begin
            cyc();
            check_output("read_oe_n", 32'(SRAM_OE_n), 32'(0));
            check_output("read_valid_early", 32'(RD_VALID), 32'(0));
        end
        cyc();
        check_output("rinc_valid", 32'(RD_VALID), 32'(1));
        check_output("rinc_data", 32'(RD_DATA), 32'(8'h5A));
        check_output("rinc_oe_n", 32'(SRAM_OE_n), 32'(0));
        cyc();
        check_output("read_valid_pulse", 32'(RD_VALID), 32'(0));
        check_output("read_data_stable", 32'(RD_DATA), 32'(8'h5A));
        check_output("read_addr_inc", 32'(SRAM_A), 32'(19'h00101));
        post_checks();

        $display("[TB] reset during write");
        do_load(19'h00200);
        REQ_WR  = 2'b01;
        WR_DATA = 16'h00C3;
        cyc();
        REQ_WR = '0;
        cyc();
        cyc();
        check_output("abort_we_low", 32'(SRAM_WE_n), 32'(0));
        RESET = 1'b1;
        cyc();
        check_output("abort_strobes", 32'({SRAM_WE_n, SRAM_DQ_OE}), 32'(2'b10));
        check_output("abort_addr", 32'(SRAM_A), 32'(0));
        check_output("abort_busy", 32'(BUSY), 32'(0));
        check_output("abort_ack", 32'(ACK_WR), 32'(0));
        RESET = 1'b0;
        model_reset();
        ref_mem[19'h00200] = 8'hC3;
        cyc();
        post_checks();

        $display("[TB] randomized traffic");
        for (int b = 0; b < 80; b++) begin
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 3))
                    0:       pick = 19'($urandom);
                    1:       pick = MAX_A;
                    2:       pick = MAX_A - 19'd1;
                    default: pick = '0;
                endcase
                do_load(pick);
            end
            if ($urandom_range(0, 4) == 0) do_flag_clr();
            mask     = 2'($urandom_range(0, 3));
            rd       = ($urandom_range(0, 2) == 0);
            data     = 16'($urandom);
            dbl_data = 16'($urandom);
            dbl      = (mask == 2'b11 && $urandom_range(0, 1) == 1) ? 2'b10 : 2'b00;
            apply_stimulus(mask, data, rd, dbl, dbl_data);
            wait_idle();
            post_checks();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
